// File: rtl/vout_mosaic_reader_if.sv
// vout_mosaic_reader_if
//   FIFO-side bus of the mosaic reader: one 16-bit YUV422 word, one empty
//   flag and one read strobe per channel.
//   Ports (signals):
//     ch_q      [16*CH_NUM] FIFO read data, channel k at [16k+15:16k]
//     ch_empty  [CH_NUM]    FIFO empty flags
//     ch_rd_req [CH_NUM]    FIFO read strobes (q valid one cycle later)
//   Modports: master = reader side, slave = FIFO side.
interface vout_mosaic_reader_if #(
    parameter int CH_NUM = 4
);
    logic [16*CH_NUM-1:0] ch_q;
    logic [CH_NUM-1:0]    ch_empty;
    logic [CH_NUM-1:0]    ch_rd_req;

    modport master (output ch_rd_req, input ch_q, input ch_empty);
    modport slave  (input ch_rd_req, output ch_q, output ch_empty);
endinterface

// File: rtl/vout_mosaic_reader.sv
// vout_mosaic_reader
//   Multi-channel output compositor. The raster is tiled as COLS x ROWS;
//   for each requested pixel the FIFO of the tile under the raster position
//   is read and its YUV422 word expanded to YUV444. Also generates the
//   per-frame FIFO clear pulse and sticky per-channel underflow flags.
//   Optional feature macro: MOSAIC_BORDER_EN (draw BORDER_COLOR on the
//   first column / first line of every tile; FIFOs are still read).
//   Ports:
//     pixel_clk, rst        clock, synchronous active-high reset
//     vs                    vertical sync (active high)
//     pixel_rd_req          pixel request from timing generator
//     tile_width/height     tile size (width even, >=2; height >=1)
//     fifo                  FIFO bus (ch_q, ch_empty, ch_rd_req)
//     frame_flag            1-cycle pulse 2 cycles after vs rises
//     pixel_ycbcr, pixel_de output pixel, valid 2 cycles after request
//     underflow             sticky starvation flags, cleared per frame
module vout_mosaic_reader #(
    parameter int          COLS         = 2,
    parameter int          ROWS         = 2,
    parameter logic [23:0] BG_COLOR     = 24'h108080,
    parameter logic [23:0] BORDER_COLOR = 24'hEB8080
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    input  logic                   vs,
    input  logic                   pixel_rd_req,
    input  logic [11:0]            tile_width,
    input  logic [11:0]            tile_height,
    vout_mosaic_reader_if.master   fifo,
    output logic                   frame_flag,
    output logic [23:0]            pixel_ycbcr,
    output logic                   pixel_de,
    output logic [COLS*ROWS-1:0]   underflow
);
    localparam int          CH_NUM = COLS * ROWS;
    localparam int          SEL_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [2:0]  COLS_L = 3'(COLS);
    localparam logic [2:0]  ROWS_L = 3'(ROWS);

    logic              r_vs_d0, r_vs_d1, r_frame_flag, r_req_d;
    logic [11:0]       r_tile_x, r_tile_y;
    logic [2:0]        r_col, r_row;
    logic [CH_NUM-1:0] r_underflow;
    logic [SEL_W-1:0]  r_s1_sel;
    logic              r_s1_bg, r_s1_phase, r_s1_start, r_s1_border;
    logic [2:1]        r_vld_pipe;
    logic [23:0]       r_pixel;
    logic [7:0]        r_cb_hold, r_cr_hold;

    // Position of the pixel being requested this cycle. A concurrent
    // frame_flag forces it to (0,0).
    logic [11:0]       w_tx, w_ty;
    logic [2:0]        w_col, w_row;
    logic [5:0]        w_sel_full;
    logic [SEL_W-1:0]  w_sel;
    logic [CH_NUM-1:0] w_onehot;
    logic              w_in_grid, w_empty_sel, w_hit, w_rd, w_under, w_border;
    logic              w_x_wrap, w_y_wrap;
    logic [11:0]       w_tx_nxt;
    logic [2:0]        w_col_nxt;
    logic [15:0]       w_word;
    logic [23:0]       w_pix;
    logic [7:0]        w_cb_nxt, w_cr_nxt;

    assign w_tx  = r_frame_flag ? 12'd0 : r_tile_x;
    assign w_ty  = r_frame_flag ? 12'd0 : r_tile_y;
    assign w_col = r_frame_flag ? 3'd0  : r_col;
    assign w_row = r_frame_flag ? 3'd0  : r_row;

    assign w_in_grid  = (w_col < COLS_L) && (w_row < ROWS_L);
    assign w_sel_full = 6'(w_row) * 6'(COLS) + 6'(w_col);
    assign w_sel      = w_sel_full[SEL_W-1:0];

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < CH_NUM; k++) w_onehot[k] = (w_sel == SEL_W'(k));
    end

    assign w_empty_sel = |(w_onehot & fifo.ch_empty);
    assign w_hit       = pixel_rd_req & ~rst & w_in_grid;
    assign w_rd        = w_hit & ~w_empty_sel;
    assign w_under     = w_hit & w_empty_sel;
    assign fifo.ch_rd_req = w_rd ? w_onehot : '0;

`ifdef MOSAIC_BORDER_EN
    assign w_border = w_in_grid & ((w_tx == 12'd0) | (w_ty == 12'd0));
`else
    assign w_border = 1'b0;
`endif

    // Compare-and-increment position tracking; col/row saturate at the
    // grid size so everything right of / below the grid reads as outside.
    assign w_x_wrap  = (w_tx == tile_width - 12'd1);
    assign w_tx_nxt  = w_x_wrap ? 12'd0 : w_tx + 12'd1;
    assign w_col_nxt = (w_x_wrap && w_col != COLS_L) ? 3'(w_col + 3'd1) : w_col;
    assign w_y_wrap  = (r_tile_y == tile_height - 12'd1);

    // Stage 2: FIFO word arrives one cycle after the strobe.
    assign w_word = fifo.ch_q[{r_s1_sel, 4'b0000} +: 16];

    always_comb begin
        w_pix    = BG_COLOR;
        w_cb_nxt = r_cb_hold;
        w_cr_nxt = r_cr_hold;
        if (r_vld_pipe[1] && !r_s1_bg) begin
            if (!r_s1_phase) begin
                // Even pixel carries Cb; at tile start the previous tile's
                // Cr must not leak in, so neutral chroma is used.
                w_pix    = {w_word[15:8], w_word[7:0], r_s1_start ? 8'h80 : r_cr_hold};
                w_cb_nxt = w_word[7:0];
                if (r_s1_start) w_cr_nxt = 8'h80;
            end else begin
                w_pix    = {w_word[15:8], r_cb_hold, w_word[7:0]};
                w_cr_nxt = w_word[7:0];
            end
        end
        if (r_vld_pipe[1] && r_s1_border) w_pix = BORDER_COLOR;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_vs_d0      <= 1'b0;
            r_vs_d1      <= 1'b0;
            r_frame_flag <= 1'b0;
            r_req_d      <= 1'b0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_underflow  <= '0;
            r_s1_sel     <= '0;
            r_s1_bg      <= 1'b1;
            r_s1_phase   <= 1'b0;
            r_s1_start   <= 1'b0;
            r_s1_border  <= 1'b0;
            r_vld_pipe   <= '0;
            r_pixel      <= BG_COLOR;
            r_cb_hold    <= 8'h00;
            r_cr_hold    <= 8'h80;
        end else begin
            r_vs_d0      <= vs;
            r_vs_d1      <= r_vs_d0;
            r_frame_flag <= r_vs_d0 & ~r_vs_d1;
            r_req_d      <= pixel_rd_req;

            if (pixel_rd_req) begin
                r_tile_x <= w_tx_nxt;
                r_col    <= w_col_nxt;
                r_tile_y <= w_ty;
                r_row    <= w_row;
            end else if (r_frame_flag) begin
                r_tile_x <= '0;
                r_col    <= '0;
                r_tile_y <= '0;
                r_row    <= '0;
            end else if (r_req_d) begin
                // End of line.
                r_tile_x <= '0;
                r_col    <= '0;
                r_tile_y <= w_y_wrap ? 12'd0 : r_tile_y + 12'd1;
                if (w_y_wrap && r_row != ROWS_L) r_row <= 3'(r_row + 3'd1);
            end

            r_underflow <= (r_frame_flag ? '0 : r_underflow) | (w_under ? w_onehot : '0);

            r_s1_sel    <= w_sel;
            r_s1_bg     <= ~w_in_grid | w_empty_sel;
            r_s1_phase  <= w_tx[0];
            r_s1_start  <= (w_tx == 12'd0);
            r_s1_border <= w_border;
            r_vld_pipe  <= {r_vld_pipe[1], pixel_rd_req};

            r_pixel   <= w_pix;
            r_cb_hold <= w_cb_nxt;
            r_cr_hold <= w_cr_nxt;
        end
    end

    assign frame_flag  = r_frame_flag;
    assign pixel_ycbcr = r_pixel;
    assign pixel_de    = r_vld_pipe[2];
    assign underflow   = r_underflow;
endmodule

// File: doc/vout_mosaic_reader.md
# vout_mosaic_reader

Parametrised multi-channel output compositor for the quad-CVBS display path. It sits between the per-channel scaled-output FIFOs (16-bit YUV422, normal-mode, 1-cycle read latency) and the timing generator. The output raster is tiled as a COLS×ROWS grid. For every requested pixel the block reads the FIFO of the tile under the raster position and converts YUV422 to YUV444. It also generates the per-frame FIFO clear pulse and flags starved channels.

## Interface
Parameters:
- COLS, 2, tile columns (1–4)
- ROWS, 2, tile rows (1–4); CH_NUM = COLS*ROWS is a derived localparam
- BG_COLOR, 24'h108080, {Y,Cb,Cr} used outside tiles and on underflow
- BORDER_COLOR, 24'hEB8080, {Y,Cb,Cr} tile border (see Configuration)

Ports (one clock, pixel_clk; synchronous active-high reset rst):
- pixel_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vs  in  1  output vertical sync, active high
- pixel_rd_req  in  1  pixel request from timing generator (active-video DE)
- tile_width  in  12  tile width in pixels, even, ≥2
- tile_height  in  12  tile height in lines, ≥1
- ch_q  in  16*CH_NUM  FIFO data, channel k at [16k+15:16k], {Y[15:8], C[7:0]}
- ch_empty  in  CH_NUM  FIFO empty flags
- ch_rd_req  out  CH_NUM  FIFO read strobes
- frame_flag  out  1  one-cycle pulse on vs rising edge (FIFO aclr)
- pixel_ycbcr  out  24  {Y,Cb,Cr}
- pixel_de  out  1  pixel_ycbcr valid
- underflow  out  CH_NUM  sticky per-channel starvation flags

## Operation
- vs is registered twice (vs_d0, vs_d1). frame_flag <= vs_d0 & ~vs_d1. On frame_flag: x/y counters, tile indices and underflow are cleared.
- Position counters always hold the position of the *next* requested pixel:
  - tile_x, col_idx: advance on each pixel_rd_req cycle. tile_x wraps at tile_width-1, which increments col_idx (saturating at COLS).
  - Falling edge of pixel_rd_req (end of line): tile_x=0, col_idx=0. tile_y advances and wraps at tile_height-1, which increments row_idx (saturating at ROWS).
  - No divider; only compare-and-increment.
- Selection, combinational in the request cycle: sel = row_idx*COLS + col_idx, valid only when col_idx<COLS and row_idx<ROWS.
- ch_rd_req[sel] = pixel_rd_req & in_grid & ~ch_empty[sel]. At most one bit is set; all others are 0.
- If in_grid and ch_empty[sel]: no read, underflow[sel] <= 1, and the pixel is substituted with BG_COLOR.
- Stage 1 (+1 cycle) captures the source: FIFO word, or a BG flag, plus the phase bit (tile_x[0]) and a tile-start flag.
- Stage 2 (+2 cycles) does YUV422→444:
  - Y = word[15:8].
  - Even phase: Cb = C; cb_hold <= C.
  - Odd phase: Cr = C; cr_hold <= C.
  - The missing component comes from its hold register.
  - At tile start (tile_x==0), cr_hold is forced to 8'h80, so the first pixel of each tile has Cr = 8'h80.
  - A BG pixel outputs BG_COLOR and does not update the hold registers.
- Outside the grid: BG_COLOR, no read, no underflow.
- rst (any cycle, including mid-line) clears everything. A line already in flight resumes counting from position 0 only after the next frame_flag; until then, counters start at 0.

## Timing
- Reset values:
  - ch_rd_req = 0, frame_flag = 0, pixel_ycbcr = BG_COLOR, pixel_de = 0, underflow = 0.
  - All counters and hold registers are 0, except cr_hold, which resets to 8'h80.
- Latency: pixel_rd_req at cycle n, so pixel_de and pixel_ycbcr at n+2. pixel_de is pixel_rd_req delayed by 2, with no gaps inserted.
- ch_rd_req is combinational from pixel_rd_req and registered state. The FIFO must supply q at n+1.
- frame_flag is high 2 cycles after vs rises. If pixel_rd_req and frame_flag coincide, the counter clear wins and the pixel is treated as position (0,0).
- Back-to-back lines with a single idle cycle are supported.

## Configuration
- MOSAIC_BORDER_EN defined:
  - Pixels with tile_x==0 or tile_y==0 inside the grid output BORDER_COLOR.
  - The FIFO is still read (word discarded; underflow still detected) so tile content stays aligned.
  - Chroma hold registers still update from the read word.
- Undefined: no border logic; all in-grid pixels come from the FIFOs.

## Test plan
- 2×2 grid, tile 4×2, raster 8×4, all FIFOs full with channel-unique Y (ch k → Y=8'h10+k):
  - ch_rd_req one-hot follows 0,0,0,0,1,1,1,1 on lines 0–1 and 2,…,3 on lines 2–3.
  - pixel_ycbcr Y matches, 2-cycle latency.
- Chroma, ch0 words {40,A0},{41,B0},{42,C0},{43,D0}:
  - Outputs {40,A0,80}, {41,A0,B0}, {42,C0,B0}, {43,C0,D0}.
- ch_empty[1] held high during line 0:
  - Tile-1 pixels output 24'h108080, ch_rd_req[1] stays 0, underflow=4'b0010.
  - underflow clears on the next vs rising edge (frame_flag).
- Raster 10 wide with COLS*tile_width=8: pixels 8–9 are BG with no read.
- rst asserted mid-line for 1 cycle: all outputs return to reset values the next cycle; no ch_rd_req until pixel_rd_req resumes.
- With MOSAIC_BORDER_EN: first column and first line of each tile = 24'hEB8080 while ch_rd_req still pulses for those pixels.
